// File: rtl/u712_cycle_sizer.sv
`default_nettype none
// ============================================================================
// Module   : u712_cycle_sizer
// Purpose  : Splits a 32-bit CPU bus cycle into one or two 16-bit chipset
//            cycles. Drives the 16-bit strobes and word address, waits for a
//            synchronized DTACKn, and returns TACKn (done) or BERRn (timeout).
// Ports    : CLK40    - sole clock, rising edge
//            RESETn   - synchronous active-low reset
//            START    - one-clock cycle request (ignored while BUSY)
//            RnW/A/SIZ- direction, CPU A[1:0], CPU SIZ[1:0], taken with START
//            DTACKn   - asynchronous chipset acknowledge, active-low
//            ASn/UDSn/LDSn - 16-bit address and data strobes
//            A1_OUT   - word address to the chipset
//            WORD_SEL - CPU data lane of the active word (0 = D31:16)
//            LATCH    - one-clock read-data capture pulse
//            TACKn    - one-clock transfer acknowledge to the CPU
//            BERRn    - one-clock bus error to the CPU
//            BUSY     - high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module u712_cycle_sizer #(
   parameter int AS_SETUP = 2,
   parameter int DS_HOLD  = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic       CLK40,
   input  logic       RESETn,
   input  logic       START,
   input  logic       RnW,
   input  logic [1:0] A,
   input  logic [1:0] SIZ,
   input  logic       DTACKn,
   output logic       ASn,
   output logic       UDSn,
   output logic       LDSn,
   output logic       A1_OUT,
   output logic       WORD_SEL,
   output logic       LATCH,
   output logic       TACKn,
   output logic       BERRn,
   output logic       BUSY
);

   // One counter serves setup, strobe timeout and hold, so it is sized
   // for the largest of the three.
   localparam int c_cnt_max = (TIMEOUT > AS_SETUP) ?
                              ((TIMEOUT > DS_HOLD) ? TIMEOUT : DS_HOLD) :
                              ((AS_SETUP > DS_HOLD) ? AS_SETUP : DS_HOLD);
   localparam int c_cnt_w = $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_setup_last   = c_cnt_w'(AS_SETUP - 1);
   localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(DS_HOLD - 1);
   localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_STROBE  = 3'd2,
      ST_LATCH   = 3'd3,
      ST_RELEASE = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               word_q, word_d;    // 1 while running the second word
   logic               long_q, long_d;
   logic               rnw_q, rnw_d;
   logic               sel_u_q, sel_u_d;
   logic               sel_l_q, sel_l_d;
   logic               a1_q, a1_d;
   logic               sync1_q, sync2_q;
   logic               asn_q, asn_d;
   logic               udsn_q, udsn_d;
   logic               ldsn_q, ldsn_d;
   logic               latch_q, latch_d;
   logic               tackn_q, tackn_d;
   logic               berrn_q, berrn_d;
   logic               busy_q, busy_d;
   logic               strobe_on;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      long_d  = long_q;
      rnw_d   = rnw_q;
      sel_u_d = sel_u_q;
      sel_l_d = sel_l_q;
      a1_d    = a1_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_ADDR;
               cnt_d   = '0;
               word_d  = 1'b0;
               rnw_d   = RnW;
               long_d  = (SIZ[1] == SIZ[0]);
               // Longword and even word use both lanes; an odd word
               // degrades to a byte at A[0]=1 (lower strobe only).
               sel_u_d = (SIZ[1] == SIZ[0]) | ~A[0];
               sel_l_d = (SIZ[1] == SIZ[0]) | A[0] | (SIZ == 2'b10);
               a1_d    = (SIZ[1] == SIZ[0]) ? 1'b0 : A[1];
            end
         end
         ST_ADDR: begin
            if (cnt_q == c_setup_last) begin
               state_d = ST_STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
         ST_STROBE: begin
            // An acknowledge on the last counted clock still wins over timeout.
            if (!sync2_q) begin
               state_d = ST_LATCH;
               cnt_d   = '0;
            end else if (cnt_q == c_timeout_last) begin
               state_d = ST_ERROR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
         ST_LATCH: begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
         end
         ST_RELEASE: begin
            if (cnt_q == c_hold_last) begin
               cnt_d = '0;
               if (long_q && !word_q) begin
                  state_d = ST_ADDR;
                  word_d  = 1'b1;
                  a1_d    = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so that, once registered,
      // they line up with the state they belong to. Writes hold the data
      // strobes off for the first STROBE clock to give write data setup.
      strobe_on = ((state_d == ST_STROBE) && (rnw_q || (state_q == ST_STROBE))) ||
                  (state_d == ST_LATCH);
      asn_d     = !(state_d inside {ST_ADDR, ST_STROBE, ST_LATCH});
      udsn_d    = !(strobe_on && sel_u_q);
      ldsn_d    = !(strobe_on && sel_l_q);
      latch_d   = (state_d == ST_LATCH) && rnw_q;
      tackn_d   = (state_d != ST_DONE);
      berrn_d   = (state_d != ST_ERROR);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK40) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= 1'b0;
         long_q  <= 1'b0;
         rnw_q   <= 1'b0;
         sel_u_q <= 1'b0;
         sel_l_q <= 1'b0;
         a1_q    <= 1'b0;
         sync1_q <= 1'b1;   // cleared to the negated acknowledge level
         sync2_q <= 1'b1;
         asn_q   <= 1'b1;
         udsn_q  <= 1'b1;
         ldsn_q  <= 1'b1;
         latch_q <= 1'b0;
         tackn_q <= 1'b1;
         berrn_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         long_q  <= long_d;
         rnw_q   <= rnw_d;
         sel_u_q <= sel_u_d;
         sel_l_q <= sel_l_d;
         a1_q    <= a1_d;
         sync1_q <= DTACKn;
         sync2_q <= sync1_q;
         asn_q   <= asn_d;
         udsn_q  <= udsn_d;
         ldsn_q  <= ldsn_d;
         latch_q <= latch_d;
         tackn_q <= tackn_d;
         berrn_q <= berrn_d;
         busy_q  <= busy_d;
      end
   end

   assign ASn      = asn_q;
   assign UDSn     = udsn_q;
   assign LDSn     = ldsn_q;
   assign A1_OUT   = a1_q;
   assign WORD_SEL = a1_q;   // the active word's lane follows its address
   assign LATCH    = latch_q;
   assign TACKn    = tackn_q;
   assign BERRn    = berrn_q;
   assign BUSY     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_u712_cycle_sizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_u712_cycle_sizer
// Purpose  : Scoreboard bench for u712_cycle_sizer. A cycle-level reference
//            model turns each issued request into a list of expected bus
//            events (strobe fall, LATCH, TACKn, BERRn) with absolute cycle
//            numbers; a monitor pops and compares them as the DUT shows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u712_cycle_sizer;

   localparam int AS      = 2;
   localparam int DH      = 1;
   localparam int TO      = 16;
   localparam int D_NEVER = 1000;

   localparam int K_STRB  = 0;
   localparam int K_LATCH = 1;
   localparam int K_TACK  = 2;
   localparam int K_BERR  = 3;

   typedef struct {
      int   kind;
      int   t;
      logic a1;
      logic ws;
      logic asn;
      logic uds;
      logic lds;
   } ev_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic       rnw;
   logic [1:0] a;
   logic [1:0] siz;
   logic       dtackn;
   logic       asn, udsn, ldsn, a1_out, word_sel, latch, tackn, berrn, busy;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   dly_cfg = D_NEVER;
   ev_t  exp_q[$];

   u712_cycle_sizer #(
      .AS_SETUP (AS),
      .DS_HOLD  (DH),
      .TIMEOUT  (TO)
   ) dut (
      .CLK40    (clk),
      .RESETn   (resetn),
      .START    (start),
      .RnW      (rnw),
      .A        (a),
      .SIZ      (siz),
      .DTACKn   (dtackn),
      .ASn      (asn),
      .UDSn     (udsn),
      .LDSn     (ldsn),
      .A1_OUT   (a1_out),
      .WORD_SEL (word_sel),
      .LATCH    (latch),
      .TACKn    (tackn),
      .BERRn    (berrn),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chipset: pulls DTACKn low dly_cfg clocks after it first sees a data
   // strobe, and releases it as soon as both strobes are negated.
   initial begin
      int dcnt;
      dtackn = 1'b1;
      dcnt   = 0;
      forever begin
         @(negedge clk);
         if (udsn && ldsn) begin
            dtackn = 1'b1;
            dcnt   = 0;
         end else if (dcnt >= dly_cfg) begin
            dtackn = 1'b0;
         end else begin
            dcnt++;
         end
      end
   end

   // Reference model. base = first ADDR cycle. The synchronized acknowledge
   // is visible two clocks after the chipset drives it; STROBE lasts at most
   // TO clocks starting AS clocks after base.
   function automatic void model_push(input logic r, input logic [1:0] aa,
                                      input logic [1:0] ss, input int d,
                                      input int base);
      bit  lng;
      bit  u, l;
      int  nw, t, s0, s, acc;
      ev_t e;
      lng = (ss[1] == ss[0]);
      nw  = lng ? 2 : 1;
      if (lng || (ss == 2'b10 && !aa[0])) begin
         u = 1'b1; l = 1'b1;
      end else begin
         u = !aa[0]; l = aa[0];
      end
      t = base;
      for (int w = 0; w < nw; w++) begin
         logic a1;
         a1  = lng ? w[0] : aa[1];
         s0  = t + AS;
         s   = s0 + (r ? 0 : 1);
         e   = '{K_STRB, s, a1, a1, 1'b0, ~u, ~l};
         exp_q.push_back(e);
         acc = s + d + 2;
         if (d >= D_NEVER || acc > s0 + TO - 1) begin
            e = '{K_BERR, s0 + TO, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            exp_q.push_back(e);
            return;
         end
         if (r) begin
            e = '{K_LATCH, acc + 1, a1, a1, 1'b0, ~u, ~l};
            exp_q.push_back(e);
         end
         t = acc + 2 + DH;
      end
      e = '{K_TACK, t, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_q.push_back(e);
   endfunction

   task automatic check_ev(input int kind);
      ev_t e;
      bit  bad;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required none", kind, cyc);
         return;
      end
      e   = exp_q.pop_front();
      bad = (e.kind != kind) || (e.t != cyc) || (asn !== e.asn) ||
            (udsn !== e.uds) || (ldsn !== e.lds);
      if (kind == K_STRB || kind == K_LATCH)
         bad = bad || (a1_out !== e.a1) || (word_sel !== e.ws);
      if (bad) begin
         errors++;
         $display("FAIL event: got kind=%0d cyc=%0d asn=%b uds=%b lds=%b a1=%b ws=%b, required kind=%0d cyc=%0d asn=%b uds=%b lds=%b a1=%b ws=%b",
                  kind, cyc, asn, udsn, ldsn, a1_out, word_sel,
                  e.kind, e.t, e.asn, e.uds, e.lds, e.a1, e.ws);
      end
   endtask

   // Monitor
   initial begin
      bit strb_prev;
      bit strb_now;
      strb_prev = 1'b0;
      forever begin
         @(negedge clk);
         strb_now = !udsn || !ldsn;
         if (strb_now && !strb_prev) check_ev(K_STRB);
         if (latch)  check_ev(K_LATCH);
         if (!tackn) check_ev(K_TACK);
         if (!berrn) check_ev(K_BERR);
         if (!tackn || !berrn) begin
            checks++;
            if (!tackn && !berrn) begin
               errors++;
               $display("FAIL tack_berr_exclusive: got both low at cycle %0d, required at most one", cyc);
            end
         end
         strb_prev = strb_now;
      end
   end

   task automatic check_outs(input string name, input logic [8:0] req);
      logic [8:0] got;
      got = {asn, udsn, ldsn, tackn, berrn, a1_out, word_sel, latch, busy};
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b (ASn UDSn LDSn TACKn BERRn A1 WS LATCH BUSY)",
                  name, got, req);
      end
   endtask

   // Called right after a negedge with the DUT idle; returns after the
   // accepting edge, at the negedge of the first ADDR clock.
   task automatic launch(input logic r, input logic [1:0] aa, input logic [1:0] ss,
                         input int d, input bit do_model, output int base);
      dly_cfg = d;
      rnw     = r;
      a       = aa;
      siz     = ss;
      start   = 1'b1;
      base    = cyc + 1;
      if (do_model) model_push(r, aa, ss, d, base);
      @(negedge clk);
      start = 1'b0;
      rnw   = 1'($urandom_range(0, 1));
      a     = 2'($urandom_range(0, 3));
      siz   = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_idle(input bit pulse);
      int n;
      n = 0;
      while (busy && n < 400) begin
         start = pulse && ($urandom_range(0, 5) == 0);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL idle_wait: got BUSY=%b after %0d clocks, required 0", busy, n);
      end
   endtask

   // Waits for the TACKn/BERRn pulse, then checks the following clock is idle.
   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (tackn && berrn && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tackn && berrn) begin
         errors++;
         $display("FAIL %s_end_wait: got no TACKn/BERRn in %0d clocks, required one", name, n);
      end
      @(negedge clk);
      check_outs({name, "_after"}, {5'b11111, a1_out, word_sel, 1'b0, 1'b0});
   endtask

   initial begin
      int base;
      int n;
      resetn = 1'b0;
      start  = 1'b0;
      rnw    = 1'b0;
      a      = 2'b00;
      siz    = 2'b00;
      repeat (3) @(negedge clk);
      check_outs("reset_values", 9'b11111_0000);
      resetn = 1'b1;
      @(negedge clk);
      check_outs("idle_after_reset", 9'b11111_0000);

      // Longword read, DTACKn 3 clocks after each strobe
      launch(1'b1, 2'b00, 2'b00, 3, 1'b1, base);
      wait_end("lw_read");
      // Byte write at odd address
      launch(1'b0, 2'b01, 2'b01, 2, 1'b1, base);
      wait_end("byte_write");
      // Word read at A=10
      launch(1'b1, 2'b10, 2'b10, 1, 1'b1, base);
      wait_end("word_read");
      // No acknowledge -> bus error
      launch(1'b1, 2'b00, 2'b10, D_NEVER, 1'b1, base);
      wait_end("timeout");
      // Odd word write (lower strobe only), acknowledge on the last legal clock
      launch(1'b0, 2'b11, 2'b10, TO - 4, 1'b1, base);
      wait_end("odd_word_last_ack");
      // Longword write, acknowledge one clock too late
      launch(1'b0, 2'b00, 2'b11, TO - 3, 1'b1, base);
      wait_end("lw_write_late_ack");

      // START in the DONE clock is ignored; START the clock after is taken
      launch(1'b0, 2'b10, 2'b10, 1, 1'b1, base);
      n = 0;
      while (tackn && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tackn) begin
         errors++;
         $display("FAIL b2b_done_wait: got TACKn=%b, required 0", tackn);
      end
      start = 1'b1;
      @(negedge clk);
      check_outs("start_in_done_ignored", {5'b11111, a1_out, word_sel, 1'b0, 1'b0});
      launch(1'b1, 2'b00, 2'b11, 2, 1'b1, base);
      wait_idle(1'b0);

      // Reset during the first word's STROBE of a longword read
      launch(1'b1, 2'b00, 2'b00, D_NEVER, 1'b0, base);
      exp_q.push_back('{K_STRB, base + AS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      while (cyc < base + AS + 1) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check_outs("reset_mid_transfer", 9'b11111_0000);
      resetn = 1'b1;
      repeat (TO + 10) @(negedge clk);
      check_outs("no_resume_after_reset", 9'b11111_0000);

      // Randomized traffic, with stray START pulses while busy
      for (int i = 0; i < 40; i++) begin
         logic       r;
         logic [1:0] aa, ss;
         int         d, mode;
         r    = 1'($urandom_range(0, 1));
         aa   = 2'($urandom_range(0, 3));
         ss   = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 19);
         if (mode < 14)      d = $urandom_range(0, 6);
         else if (mode < 16) d = D_NEVER;
         else                d = TO - 3 - (r ? 0 : 1) + ((mode < 18) ? 0 : 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         launch(r, aa, ss, d, 1'b1, base);
         wait_idle(1'b1);
      end

      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d events outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
